// File: rtl/sensor_scan_pkg.sv
// Shared types and default constants for the line-sensor frame sequencer.
// Build option: define SCAN_TIMEOUT_EN to enable the READOUT watchdog.
package sensor_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_INTEG   = 2'd1,
        S_READOUT = 2'd2,
        S_GAP     = 2'd3
    } scan_state_e;

    localparam int DEF_DIV     = 8;
    localparam int DEF_INTEG   = 6000;
    localparam int DEF_PERIOD  = 40000;
    localparam int DEF_PIX_W   = 11;
    localparam int DEF_CNT_W   = 21;
    localparam int DEF_TIMEOUT = 4096;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous sensor pin followed by a
// registered rising-edge detector; rise_o is a one-cycle pulse.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sensor_scan_ctrl.sv
// Frame sequencer for the line image sensor: SENSOR_CLK divider, ST pulse,
// EOC pixel strobes and EOS frame close. Build option: SCAN_TIMEOUT_EN.
module sensor_scan_ctrl
    import sensor_scan_pkg::*;
#(
    parameter int DIV     = DEF_DIV,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PIX_W   = DEF_PIX_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             FPGA_CLK,
    input  logic             FPGA_RST,
    input  logic             START,
    input  logic             CONT,
    input  logic             ABORT,
    input  logic [CNT_W-1:0] INTEG,
    input  logic [CNT_W-1:0] PERIOD,
    input  logic             EOC,
    input  logic             EOS,
    output logic             SENSOR_CLK,
    output logic             ST,
    output logic             PIX_VALID,
    output logic [PIX_W-1:0] PIX_IDX,
    output logic             FRAME_DONE,
    output logic [PIX_W-1:0] PIX_COUNT,
    output logic             BUSY,
    output logic             ERR_TIMEOUT,
    output scan_state_e      dbg_state_o
);

    localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [PIX_W-1:0] PIX_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [DIV_W-1:0] div_cnt_q;
    logic             sclk_q;
    logic             div_tick;
    logic             sclk_rise;
    logic             sclk_fall;

    scan_state_e      state_q, state_d;
    logic             st_q, st_d;
    logic [CNT_W-1:0] integ_len_q, integ_len_d;
    logic [CNT_W-1:0] period_len_q, period_len_d;
    logic [CNT_W-1:0] integ_cnt_q, integ_cnt_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [PIX_W-1:0] pix_cnt_inc;
    logic             pix_valid_q, pix_valid_d;
    logic [PIX_W-1:0] pix_idx_q, pix_idx_d;
    logic             frame_done_q, frame_done_d;
    logic [PIX_W-1:0] pix_count_q, pix_count_d;

    logic eoc_rise;
    logic eos_rise;

`ifdef SCAN_TIMEOUT_EN
    localparam int              WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_TIMEOUT = WD_W'(TIMEOUT);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            err_q, err_d;
    assign ERR_TIMEOUT = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign ERR_TIMEOUT    = 1'b0;
`endif

    sync_edge_det u_eoc_det (
        .clk_i   (FPGA_CLK),
        .rst_ni  (FPGA_RST),
        .async_i (EOC),
        .rise_o  (eoc_rise)
    );

    sync_edge_det u_eos_det (
        .clk_i   (FPGA_CLK),
        .rst_ni  (FPGA_RST),
        .async_i (EOS),
        .rise_o  (eos_rise)
    );

    // Ticks fire in the same cycle the divided clock register toggles.
    assign div_tick  = (div_cnt_q == DIV_LAST);
    assign sclk_rise = div_tick & ~sclk_q;
    assign sclk_fall = div_tick &  sclk_q;

    always_comb begin
        state_d      = state_q;
        st_d         = st_q;
        integ_len_d  = integ_len_q;
        period_len_d = period_len_q;
        integ_cnt_d  = integ_cnt_q;
        per_cnt_d    = per_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        pix_valid_d  = 1'b0;
        pix_idx_d    = pix_idx_q;
        frame_done_d = 1'b0;
        pix_count_d  = pix_count_q;
        pix_cnt_inc  = (pix_cnt_q == PIX_MAX) ? pix_cnt_q : pix_cnt_q + PIX_W'(1);
`ifdef SCAN_TIMEOUT_EN
        wd_cnt_d     = wd_cnt_q;
        err_d        = err_q;
`endif

        // Frame period counter; re-zeroed at every ST rise.
        if (state_q != S_IDLE && sclk_rise && per_cnt_q != CNT_MAX) begin
            per_cnt_d = per_cnt_q + CNT_W'(1);
        end

        if (ABORT) begin
            state_d = S_IDLE;
            st_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        integ_len_d  = (INTEG == '0) ? CNT_W'(1) : INTEG;
                        period_len_d = PERIOD;
                        pix_cnt_d    = '0;
                        state_d      = S_INTEG;
`ifdef SCAN_TIMEOUT_EN
                        err_d        = 1'b0;
`endif
                    end
                end
                S_INTEG: begin
                    if (!st_q) begin
                        if (sclk_fall) begin
                            st_d        = 1'b1;
                            per_cnt_d   = '0;
                            integ_cnt_d = '0;
                        end
                    end else begin
                        if (sclk_rise) begin
                            integ_cnt_d = integ_cnt_q + CNT_W'(1);
                        end
                        if (sclk_fall && integ_cnt_q >= integ_len_q) begin
                            st_d    = 1'b0;
                            state_d = S_READOUT;
`ifdef SCAN_TIMEOUT_EN
                            wd_cnt_d = '0;
`endif
                        end
                    end
                end
                S_READOUT: begin
`ifdef SCAN_TIMEOUT_EN
                    if (sclk_rise && wd_cnt_q != WD_TIMEOUT) begin
                        wd_cnt_d = wd_cnt_q + WD_W'(1);
                    end
`endif
                    // A pixel arriving with EOS is counted before the frame closes.
                    if (eoc_rise) begin
                        pix_valid_d = 1'b1;
                        pix_idx_d   = pix_cnt_q;
                        pix_cnt_d   = pix_cnt_inc;
                    end
                    if (eos_rise) begin
                        pix_count_d  = pix_cnt_d;
                        frame_done_d = 1'b1;
                        state_d      = S_GAP;
                    end
`ifdef SCAN_TIMEOUT_EN
                    else if (wd_cnt_q == WD_TIMEOUT) begin
                        pix_count_d  = pix_cnt_d;
                        frame_done_d = 1'b1;
                        err_d        = 1'b1;
                        state_d      = S_IDLE;
                    end
`endif
                end
                S_GAP: begin
                    if (per_cnt_q >= period_len_q) begin
                        if (CONT) begin
                            integ_len_d  = (INTEG == '0) ? CNT_W'(1) : INTEG;
                            period_len_d = PERIOD;
                            pix_cnt_d    = '0;
                            state_d      = S_INTEG;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
        if (!FPGA_RST) begin
            div_cnt_q    <= '0;
            sclk_q       <= 1'b0;
            state_q      <= S_IDLE;
            st_q         <= 1'b0;
            integ_len_q  <= '0;
            period_len_q <= '0;
            integ_cnt_q  <= '0;
            per_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            pix_valid_q  <= 1'b0;
            pix_idx_q    <= '0;
            frame_done_q <= 1'b0;
            pix_count_q  <= '0;
`ifdef SCAN_TIMEOUT_EN
            wd_cnt_q     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            div_cnt_q    <= div_tick ? '0 : div_cnt_q + DIV_W'(1);
            sclk_q       <= div_tick ? ~sclk_q : sclk_q;
            state_q      <= state_d;
            st_q         <= st_d;
            integ_len_q  <= integ_len_d;
            period_len_q <= period_len_d;
            integ_cnt_q  <= integ_cnt_d;
            per_cnt_q    <= per_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            pix_valid_q  <= pix_valid_d;
            pix_idx_q    <= pix_idx_d;
            frame_done_q <= frame_done_d;
            pix_count_q  <= pix_count_d;
`ifdef SCAN_TIMEOUT_EN
            wd_cnt_q     <= wd_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign SENSOR_CLK  = sclk_q;
    assign ST          = st_q;
    assign PIX_VALID   = pix_valid_q;
    assign PIX_IDX     = pix_idx_q;
    assign FRAME_DONE  = frame_done_q;
    assign PIX_COUNT   = pix_count_q;
    assign BUSY        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Directed bench for sensor_scan_ctrl with DIV=2 (4 FPGA clocks per sensor clock).
module tb_sensor_scan_ctrl;
    import sensor_scan_pkg::*;

    localparam int DIV     = 2;
    localparam int CNT_W   = 21;
    localparam int PIX_W   = 11;
    localparam int TIMEOUT = 32;
    localparam int W       = PIX_W + 1;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b1;
    logic             start  = 1'b0;
    logic             cont   = 1'b0;
    logic             abort  = 1'b0;
    logic             eoc    = 1'b0;
    logic             eos    = 1'b0;
    logic [CNT_W-1:0] integ  = 21'd4;
    logic [CNT_W-1:0] period = 21'd64;

    logic             sensor_clk, st, pix_valid, frame_done, busy, err_timeout;
    logic [PIX_W-1:0] pix_idx, pix_count;
    scan_state_e      dbg_state;

    sensor_scan_ctrl #(.DIV(DIV), .CNT_W(CNT_W), .PIX_W(PIX_W), .TIMEOUT(TIMEOUT)) dut (
        .FPGA_CLK    (clk),
        .FPGA_RST    (rst_n),
        .START       (start),
        .CONT        (cont),
        .ABORT       (abort),
        .INTEG       (integ),
        .PERIOD      (period),
        .EOC         (eoc),
        .EOS         (eos),
        .SENSOR_CLK  (sensor_clk),
        .ST          (st),
        .PIX_VALID   (pix_valid),
        .PIX_IDX     (pix_idx),
        .FRAME_DONE  (frame_done),
        .PIX_COUNT   (pix_count),
        .BUSY        (busy),
        .ERR_TIMEOUT (err_timeout),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    // Entry: {1'b0, pixel index} for PIX_VALID, {1'b1, count} for FRAME_DONE.
    logic [W-1:0] exp_q[$];
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name, input logic [W-1:0] act);
        logic [W-1:0] exp;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected output %0h with nothing expected", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got %0h, expected %0h", name, act, exp);
            end
        end
    endtask

    // ---------------- monitor ----------------
    int   st_rise_cnt = 0;
    int   st_rise_cyc = 0;
    int   st_fall_cyc = 0;
    int   st_high_len = 0;
    int   busy_fall_cyc = 0;
    int   fd_cyc = 0;
    logic st_prev = 1'b0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (st && !st_prev) begin
                st_rise_cnt++;
                st_rise_cyc = cyc;
            end
            if (!st && st_prev) begin
                st_fall_cyc = cyc;
                st_high_len = cyc - st_rise_cyc;
            end
            if (!busy && busy_prev) busy_fall_cyc = cyc;
            if (pix_valid) pop_check("pix_idx", {1'b0, pix_idx});
            if (frame_done) begin
                fd_cyc = cyc;
                pop_check("frame_count", {1'b1, pix_count});
            end
        end
        st_prev   = st;
        busy_prev = busy;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_state(input string name, input scan_state_e s, input int budget);
        int n = 0;
        while (dbg_state != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(dbg_state == s), 1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    task automatic send_pix(input int idx);
        exp_q.push_back({1'b0, PIX_W'((idx > 2047) ? 2047 : idx)});
        eoc = 1'b1;
        tick(2);
        eoc = 1'b0;
        tick(2);
    endtask

    task automatic send_eos(input int count);
        exp_q.push_back({1'b1, PIX_W'(count)});
        eos = 1'b1;
        tick(2);
        eos = 1'b0;
        tick(2);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    int base;
    int r1;
    int toggles;
    logic sclk_prev;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_st",         int'(st), 0);
        check("rst_busy",       int'(busy), 0);
        check("rst_sensor_clk", int'(sensor_clk), 0);
        check("rst_pulses",     int'({pix_valid, frame_done, err_timeout}), 0);
        check("rst_pix_count",  int'(pix_count), 0);
        tick(3);
        rst_n = 1'b1;

        // SENSOR_CLK free-runs in IDLE: one toggle per DIV clocks.
        toggles = 0;
        for (int i = 0; i < 16; i++) begin
            sclk_prev = sensor_clk;
            tick(1);
            if (sensor_clk != sclk_prev) toggles++;
        end
        check("idle_sclk_toggles", toggles, 8);

        // Single frame: 10 pixels, INTEG=4, PERIOD=64.
        pulse_start();
        wait_state("f1_readout", S_READOUT, 200);
        tick(1);
        check("f1_st_high_cycles", st_high_len, 16);
        for (int i = 0; i < 10; i++) send_pix(i);
        send_eos(10);
        wait_idle("f1_idle", 400);
        tick(1);
        check("f1_busy_fall_from_st_rise", busy_fall_cyc - st_rise_cyc, 255);
        check("f1_pix_count", int'(pix_count), 10);
        drain("f1_drain");

        // Continuous frames, CONT dropped during frame 2.
        base = st_rise_cnt;
        cont = 1'b1;
        pulse_start();
        wait_state("c1_readout", S_READOUT, 200);
        tick(1);
        r1 = st_rise_cyc;
        for (int i = 0; i < 3; i++) send_pix(i);
        send_eos(3);
        wait_state("c2_readout", S_READOUT, 400);
        tick(1);
        check("c_st_period", st_rise_cyc - r1, 256);
        cont = 1'b0;
        for (int i = 0; i < 2; i++) send_pix(i);
        send_eos(2);
        wait_idle("c2_idle", 400);
        tick(300);
        check("c_st_rises", st_rise_cnt - base, 2);
        check("c_pix_count", int'(pix_count), 2);
        drain("c_drain");

        // EOC and EOS together on the 5th pixel.
        pulse_start();
        wait_state("s_readout", S_READOUT, 200);
        tick(1);
        for (int i = 0; i < 4; i++) send_pix(i);
        exp_q.push_back({1'b0, PIX_W'(4)});
        exp_q.push_back({1'b1, PIX_W'(5)});
        eoc = 1'b1;
        eos = 1'b1;
        tick(2);
        eoc = 1'b0;
        eos = 1'b0;
        tick(2);
        wait_idle("s_idle", 400);
        check("s_pix_count", int'(pix_count), 5);
        drain("s_drain");

        // ABORT in READOUT after 3 pixels; START while busy ignored.
        base = st_rise_cnt;
        pulse_start();
        tick(2);
        pulse_start();
        wait_state("a_readout", S_READOUT, 200);
        tick(1);
        for (int i = 0; i < 3; i++) send_pix(i);
        drain("a_drain_pix");
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("a_st", int'(st), 0);
        check("a_busy", int'(busy), 0);
        check("a_state_idle", int'(dbg_state == S_IDLE), 1);
        check("a_pix_count_kept", int'(pix_count), 5);
        tick(300);
        check("a_st_rises", st_rise_cnt - base, 1);
        drain("a_no_frame_done");

        // START and ABORT together: ABORT wins.
        @(negedge clk) begin
            start = 1'b1;
            abort = 1'b1;
        end
        @(negedge clk) begin
            start = 1'b0;
            abort = 1'b0;
        end
        check("sa_busy", int'(busy), 0);

`ifdef SCAN_TIMEOUT_EN
        // Watchdog: no EOS for TIMEOUT readout sensor clocks.
        pulse_start();
        wait_state("t_readout", S_READOUT, 200);
        exp_q.push_back({1'b1, PIX_W'(0)});
        drain("t_frame_done");
        tick(2);
        check("t_fd_latency", fd_cyc - st_fall_cyc, 127);
        check("t_err", int'(err_timeout), 1);
        check("t_busy", int'(busy), 0);
        pulse_start();
        check("t_err_cleared", int'(err_timeout), 0);
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
`endif

        // Asynchronous reset mid-INTEG while SENSOR_CLK is high.
        pulse_start();
        begin
            int n = 0;
            while (!(st && sensor_clk && dbg_state == S_INTEG) && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("r_pre_st_high", int'(st && sensor_clk), 1);
        #2 rst_n = 1'b0;
        #1;
        check("r_async_st",   int'(st), 0);
        check("r_async_busy", int'(busy), 0);
        check("r_async_sclk", int'(sensor_clk), 0);
        check("r_pix_count",  int'(pix_count), 0);
        @(negedge clk) rst_n = 1'b1;
        tick(2);

`ifndef SCAN_TIMEOUT_EN
        // Pixel counter saturation: 2100 EOCs in one frame.
        integ = 21'd1;
        pulse_start();
        wait_state("p_readout", S_READOUT, 200);
        tick(1);
        for (int i = 0; i < 2100; i++) send_pix(i);
        send_eos(2047);
        wait_idle("p_idle", 400);
        check("p_pix_count_sat", int'(pix_count), 2047);
        drain("p_drain");
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_scan_ctrl.md
Name: sensor_scan_ctrl

Overview:
Frame sequencer for the line image sensor. It generates the divided SENSOR_CLK and an ST pulse of programmable width. During readout it counts EOC rising edges and emits one pixel strobe with pixel index per edge, then closes the frame on the EOS rising edge. It sits between host/readout logic and the sensor pins, and it runs single-shot or continuous frames with a fixed frame period.

Parameters:
DIV, 8, FPGA_CLK cycles per SENSOR_CLK half-period (>=2)
CNT_W, 21, width of INTEG/PERIOD and the sensor-clock counters
PIX_W, 11, width of pixel index/count
TIMEOUT, 4096, sensor-clock cycles allowed in READOUT before error

Ports:
FPGA_CLK  in  1  system clock
FPGA_RST  in  1  reset, asynchronous, active-low
START  in  1  1-cycle pulse, begin a frame
CONT  in  1  level; 1 = continuous frames
ABORT  in  1  1-cycle pulse, return to IDLE
INTEG  in  CNT_W  ST high length in sensor clocks (0 treated as 1)
PERIOD  in  CNT_W  frame period in sensor clocks, counted from ST rise
EOC  in  1  sensor end-of-conversion, asynchronous
EOS  in  1  sensor end-of-scan, asynchronous
SENSOR_CLK  out  1  divided clock, free-running
ST  out  1  sensor start pulse
PIX_VALID  out  1  1-cycle strobe per counted pixel
PIX_IDX  out  PIX_W  index of the strobed pixel, 0-based
FRAME_DONE  out  1  1-cycle pulse at frame end
PIX_COUNT  out  PIX_W  pixel count of the last completed frame
BUSY  out  1  high in any state except IDLE
ERR_TIMEOUT  out  1  sticky; cleared by START or reset

Behaviour:
- Reset (async, FPGA_RST=0): state IDLE; all outputs 0; all counters 0. Release is synchronous to FPGA_CLK.
- SENSOR_CLK toggles every DIV FPGA_CLK cycles, including in IDLE. sclk_rise/sclk_fall are internal 1-cycle ticks aligned with the toggle.
- State counters advance on sclk_rise only. ST changes only on sclk_fall ticks, giving half-period setup to the sensor.
- FSM states: IDLE, INTEG, READOUT, GAP.
  - IDLE: START latches INTEG and PERIOD, clears ERR_TIMEOUT, sets pix_cnt=0, and goes to INTEG. ST rises at the next sclk_fall.
  - INTEG: ST=1 for max(INTEG,1) sensor clocks, then ST falls at sclk_fall and the FSM goes to READOUT.
  - READOUT: each synchronized EOC rising edge produces PIX_VALID with PIX_IDX=pix_cnt, then pix_cnt is incremented.
    - pix_cnt saturates at 2^PIX_W-1; PIX_VALID is still pulsed, with PIX_IDX held at the saturated value.
    - EOS rising edge: PIX_COUNT<=pix_cnt, FRAME_DONE pulses, FSM goes to GAP.
  - GAP: wait until the period counter (started at ST rise) reaches PERIOD.
    - If PERIOD <= elapsed, leave immediately.
    - Exit goes to INTEG when CONT=1, else to IDLE. Latched INTEG/PERIOD are re-sampled at each frame start.
- EOC/EOS: 2-FF synchronizer, then a rising-edge register. Latency from pin edge to PIX_VALID or FRAME_DONE is 3–4 FPGA_CLK cycles.
- EOC edges outside READOUT are ignored. EOS outside READOUT is ignored.
- EOC and EOS edges in the same cycle: the pixel is counted first, so PIX_COUNT includes it.
- START while BUSY: ignored. CONT deasserted mid-frame: the current frame completes, then IDLE.
- ABORT: from any state to IDLE on the next FPGA_CLK; ST=0 immediately; no FRAME_DONE; PIX_COUNT unchanged.
- START and ABORT in the same cycle: ABORT wins.

Optional Feature:
SCAN_TIMEOUT_EN
- Defined: a READOUT watchdog counts sensor clocks. Reaching TIMEOUT without EOS sets ERR_TIMEOUT, loads PIX_COUNT<=pix_cnt, pulses FRAME_DONE, and goes to IDLE, even when CONT=1.
- Undefined: no watchdog, ERR_TIMEOUT tied 0, and READOUT waits for EOS indefinitely.

Decomposition:
- Package sensor_scan_pkg holds:
  - the state enum (IDLE, INTEG, READOUT, GAP)
  - default constants: DIV=8, INTEG=6000, PERIOD=40000, PIX_W=11
- One sub-module, sync_edge_det (2-FF sync plus rising-edge pulse), instantiated for EOC and EOS.
- Clock divider and FSM stay in the top module.

Test Plan:
- DIV=2, INTEG=4, PERIOD=64, START, sensor model emits 10 EOC then EOS -> ST high exactly 4 SENSOR_CLK periods; PIX_IDX 0..9 strobed; FRAME_DONE once; PIX_COUNT=10; BUSY falls after GAP ends at sensor clock 64.
- CONT=1, 3 frames -> ST rises every 64 sensor clocks; CONT=0 during frame 2 -> frame 2 completes, no third ST.
- EOC and EOS on the same edge as the 5th pixel -> PIX_COUNT=5, single FRAME_DONE.
- ABORT in READOUT after 3 pixels -> ST=0, IDLE next cycle, no FRAME_DONE, PIX_COUNT keeps previous value; START during BUSY has no effect.
- SCAN_TIMEOUT_EN, TIMEOUT=32, no EOS -> ERR_TIMEOUT=1 and FRAME_DONE after 32 readout sensor clocks; next START clears ERR_TIMEOUT.
- Async reset asserted mid-INTEG between clock edges -> ST, BUSY and SENSOR_CLK go 0 without waiting for a clock edge; 2100 EOCs in one frame -> PIX_COUNT=2047.
